vend_dispense_ctrl: RTL and testbench

Dispense scheduler behind the coin-acceptor FSM. It queues product requests (codes 1..3, matching the acceptor's 2-bit product output), checks per-product stock and drives the shared dispenser motor through a start/done handshake with a timeout. Each request ends in exactly one vend_ok pulse or one refund pulse.

---
 rtl/vend_dispense_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl
//   Dispense scheduler behind the coin acceptor. Requests (product codes 1..3)
//   are queued, checked against per-product stock and driven to the shared
//   dispenser motor through a start/done handshake with a timeout. Every
//   accepted request ends in exactly one vend_ok pulse or one refund pulse.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req_valid/code  request strobe and product code (0 = no product, dropped)
//   req_ready       queue not full (from registered occupancy)
//   refill          reload all stock counters to INIT_STOCK
//   motor_sel       product slot being driven, 0 when idle
//   motor_start     dispenser run request (level)
//   motor_done      dispenser completion (level, held until motor_start drops)
//   vend_ok         one-cycle pulse, product dispensed
//   refund_valid    one-cycle pulse, request refunded; refund_amt = code
//   busy            FSM active or queue non-empty
//   stock_empty     bit i-1 set when product i is out of stock
//   fault           sticky motor-timeout flag, cleared by reset only
//
// Optional build macro VEND_STATS_EN adds vend_cnt / refund_cnt, saturating
// 16-bit counts of vend_ok and refund_valid pulses.

module vend_dispense_ctrl #(
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_code,
  output logic        req_ready,
  input  logic        refill,
  output logic [1:0]  motor_sel,
  output logic        motor_start,
  input  logic        motor_done,
  output logic        vend_ok,
  output logic        refund_valid,
  output logic [1:0]  refund_amt,
  output logic        busy,
  output logic [2:0]  stock_empty,
`ifdef VEND_STATS_EN
  output logic [15:0] vend_cnt,
  output logic [15:0] refund_cnt,
`endif
  output logic        fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [TW-1:0]      TMO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_RELEASE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                cur_q, cur_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      vend_q, vend_d;
  logic                      refund_q, refund_d;
  logic [1:0]                amt_q, amt_d;
  logic                      fault_q, fault_d;
  logic                      dec;
  logic [2:0][STOCK_W-1:0]   stock_q;

  // Request queue; the extra pointer bit separates full from empty.
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic [1:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, push, pop, cur_out;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // Ready looks only at current occupancy, so a same-cycle pop never frees
  // a slot for a same-cycle push.
  assign push  = req_valid && !full && (req_code != 2'd0);
  assign pop   = (state_q == S_IDLE) && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= req_code;
  end

  // Stock counters; refill overrides a same-cycle decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 3; g++) stock_q[g] <= STOCK_INIT;
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (refill)
          stock_q[g] <= STOCK_INIT;
        else if (dec && (cur_q == 2'(g + 1)))
          stock_q[g] <= stock_q[g] - STOCK_W'(1);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_empty
    assign stock_empty[g] = (stock_q[g] == '0);
  end

  // Out-of-stock flag for the product currently held in cur_q.
  assign cur_out = |(stock_empty & {cur_q == 2'd3, cur_q == 2'd2, cur_q == 2'd1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_q    <= 2'd0;
      timer_q  <= '0;
      vend_q   <= 1'b0;
      refund_q <= 1'b0;
      amt_q    <= 2'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      timer_q  <= timer_d;
      vend_q   <= vend_d;
      refund_q <= refund_d;
      amt_q    <= amt_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    timer_d  = timer_q;
    vend_d   = 1'b0;
    refund_d = 1'b0;
    amt_d    = 2'd0;
    fault_d  = fault_q;
    dec      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          cur_d   = mem_q[rd_ptr_q[PW-1:0]];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cur_out) begin
          refund_d = 1'b1;
          amt_d    = cur_q;
          cur_d    = 2'd0;
          state_d  = S_IDLE;
        end else begin
          timer_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // done has priority over a timeout landing in the same cycle
        if (motor_done) begin
          dec     = 1'b1;
          vend_d  = 1'b1;
          state_d = S_RELEASE;
        end else if (timer_q == TMO_LAST) begin
          refund_d = 1'b1;
          amt_d    = cur_q;
          fault_d  = 1'b1;
          state_d  = S_RELEASE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RELEASE: begin
        if (!motor_done) begin
          cur_d   = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Motor outputs decode straight from the state register so reset drops
  // motor_start immediately.
  assign motor_start  = (state_q == S_RUN);
  assign motor_sel    = ((state_q == S_RUN) || (state_q == S_RELEASE)) ? cur_q : 2'd0;
  assign vend_ok      = vend_q;
  assign refund_valid = refund_q;
  assign refund_amt   = refund_q ? amt_q : 2'd0;
  assign fault        = fault_q;
  assign req_ready    = !full;
  assign busy         = (state_q != S_IDLE) || !empty;

`ifdef VEND_STATS_EN
  logic [15:0] vend_cnt_q, refund_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vend_cnt_q   <= 16'd0;
      refund_cnt_q <= 16'd0;
    end else begin
      if (vend_q && (vend_cnt_q != 16'hFFFF))     vend_cnt_q   <= vend_cnt_q + 16'd1;
      if (refund_q && (refund_cnt_q != 16'hFFFF)) refund_cnt_q <= refund_cnt_q + 16'd1;
    end
  end
  assign vend_cnt   = vend_cnt_q;
  assign refund_cnt = refund_cnt_q;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
module tb_vend_dispense_ctrl;
  localparam int INIT  = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0, reset = 1'b1;
  logic       req_valid = 1'b0, refill = 1'b0;
  logic [1:0] req_code = 2'd0;
  logic       req_ready, motor_start, motor_done, vend_ok, refund_valid, busy, fault;
  logic [1:0] motor_sel, refund_amt;
  logic [2:0] stock_empty;
`ifdef VEND_STATS_EN
  logic [15:0] vend_cnt, refund_cnt;
`endif

  vend_dispense_ctrl #(.STOCK_W(4), .INIT_STOCK(INIT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
    .refill(refill), .motor_sel(motor_sel), .motor_start(motor_start), .motor_done(motor_done),
    .vend_ok(vend_ok), .refund_valid(refund_valid), .refund_amt(refund_amt), .busy(busy),
    .stock_empty(stock_empty),
`ifdef VEND_STATS_EN
    .vend_cnt(vend_cnt), .refund_cnt(refund_cnt),
`endif
    .fault(fault));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Motor emulator: done rises on the (cur_d)th RUN cycle, drops with start.
  logic tie = 1'b0, done_r = 1'b0;
  int   run_cyc = 0, cur_d = 0, d_fix = 0;
  assign motor_done = tie ? motor_start : done_r;
  always @(negedge clk) begin
    if (motor_start) begin
      run_cyc++;
      done_r = (run_cyc > cur_d);
    end else begin
      run_cyc = 0;
      done_r  = 1'b0;
    end
  end

  // Behavioural model: each request is a service with a known timeline
  // (pop edge, one check cycle, r run cycles, pulse, one release cycle).
  int  q[$];
  int  stk[3];
  int  n = 0, idle_at = 0, pulse_at = -10, run_lo = 0, run_hi = -1, sel_hi = -1, p_code = 0;
  int  acc_total = 0;
  bit  p_vend = 0, p_tmo = 0, m_fault = 0;
  bit  e_vend, e_ref, e_start, e_busy, e_ready;
  int  e_amt, e_sel;
  logic [2:0] e_empty;

  always @(posedge clk or posedge reset) begin
    bit do_pop, acc;
    int d, r;
    if (reset) begin
      q.delete();
      foreach (stk[i]) stk[i] = INIT;
      idle_at = n; pulse_at = -10; run_lo = 0; run_hi = -1; sel_hi = -1;
      p_code = 0; p_vend = 0; p_tmo = 0; m_fault = 0;
    end else begin
      n++;
      do_pop = (n - 1 >= idle_at) && (q.size() > 0);
      acc    = req_valid && (req_code != 2'd0) && (q.size() < DEPTH);
      if (n == pulse_at) begin
        if (p_vend) stk[p_code-1]--;
        else if (p_tmo) m_fault = 1;
      end
      if (refill) foreach (stk[i]) stk[i] = INIT;
      if (do_pop) begin
        p_code = q.pop_front();
        if (stk[p_code-1] == 0) begin
          p_vend = 0; p_tmo = 0;
          pulse_at = n + 1; idle_at = n + 1;
          run_lo = 0; run_hi = -1; sel_hi = -1;
        end else begin
          d = tie ? 0 : (d_fix >= 0 ? d_fix : int'($urandom_range(0, 19)));
          cur_d = d;
          r = (d < TMO) ? d + 1 : TMO;
          p_vend = (d < TMO); p_tmo = !p_vend;
          run_lo = n + 1; run_hi = n + r; sel_hi = n + r + 1;
          pulse_at = n + r + 1; idle_at = n + r + 2;
        end
      end
      if (acc) begin
        q.push_back(int'(req_code));
        acc_total++;
      end
    end
    e_vend  = (n == pulse_at) && p_vend;
    e_ref   = (n == pulse_at) && !p_vend;
    e_amt   = e_ref ? p_code : 0;
    e_start = (n >= run_lo) && (n <= run_hi);
    e_sel   = ((n >= run_lo) && (n <= sel_hi)) ? p_code : 0;
    e_busy  = (n < idle_at) || (q.size() > 0);
    e_ready = (q.size() < DEPTH);
    e_empty = {stk[2] == 0, stk[1] == 0, stk[0] == 0};
  end

  // Cycle compare against the model.
  bit chk_on = 0;
  always @(posedge clk) begin
    #2;
    if (!reset && chk_on) begin
      check("vend_ok", vend_ok, e_vend);
      check("refund_valid", refund_valid, e_ref);
      check("refund_amt", refund_amt, e_amt);
      check("motor_start", motor_start, e_start);
      check("motor_sel", motor_sel, e_sel);
      check("busy", busy, e_busy);
      check("req_ready", req_ready, e_ready);
      check("stock_empty", stock_empty, e_empty);
      check("fault", fault, m_fault);
    end
  end

  // Pulse monitor for the directed literal checks.
  int m_vend = 0, m_ref = 0, m_start = 0, last_amt = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (vend_ok) m_vend++;
      if (refund_valid) begin m_ref++; last_amt = int'(refund_amt); end
      if (motor_start) m_start++;
    end
  end

  task automatic push(input logic [1:0] c);
    @(negedge clk); req_valid = 1'b1; req_code = c;
    @(negedge clk); req_valid = 1'b0; req_code = 2'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (e_busy && k < 300) begin @(negedge clk); k++; end
    check("wait_idle_bound", k < 300, 1);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!e_start && k < 100) begin @(negedge clk); k++; end
    check("wait_start_bound", k < 100, 1);
  endtask

  initial begin
    int lat, v0, r0, s0, a0;
    bit found;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_start", motor_start, 0);
    check("reset_empty", stock_empty, 3'b000);
    @(negedge clk); reset = 1'b0; chk_on = 1;

    // 1: single dispense, motor_done tied to motor_start
    tie = 1'b1; v0 = m_vend;
    @(negedge clk); req_valid = 1'b1; req_code = 2'd2;
    @(posedge clk); #1 req_valid = 1'b0; req_code = 2'd0;
    lat = 0; found = 0;
    while (!found && lat < 20) begin
      @(posedge clk); #3; lat++; found = vend_ok;
    end
    check("t1_latency", lat, 3);
    wait_idle();
    check("t1_vend_count", m_vend - v0, 1);
    check("t1_busy_low", busy, 0);
    tie = 1'b0;

    // 2: exhaust product 1 then request it again
    d_fix = 0;
    repeat (8) begin push(2'd1); wait_idle(); end
    r0 = m_ref; s0 = m_start;
    push(2'd1); wait_idle();
    check("t2_refund_count", m_ref - r0, 1);
    check("t2_refund_amt", last_amt, 1);
    check("t2_no_start", m_start - s0, 0);
    check("t2_empty0", stock_empty, 3'b001);

    // 3: motor timeout
    d_fix = 99; s0 = m_start;
    push(2'd3); wait_idle();
    check("t3_start_cycles", m_start - s0, 16);
    check("t3_refund_amt", last_amt, 3);
    check("t3_fault", fault, 1);
    check("t3_stock3_kept", stock_empty[2], 0);

    // 4: queue full behind a stalled motor
    d_fix = 99;
    push(2'd2); wait_start();
    a0 = acc_total; d_fix = 1;
    @(negedge clk); req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_code = 2'((i % 3) + 1);
      @(negedge clk);
    end
    req_valid = 1'b0; req_code = 2'd0;
    check("t4_accepted", acc_total - a0, 4);
    check("t4_ready_low", req_ready, 0);
    wait_idle();

    // 5: refill in the same cycle as a vend decrement
    d_fix = 0; v0 = m_vend;
    @(negedge clk); req_valid = 1'b1; req_code = 2'd2;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0; req_code = 2'd0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    wait_idle();
    check("t5_vend", m_vend - v0, 1);
    check("t5_empty_clear", stock_empty, 3'b000);

    // 6: reset while the motor runs
    d_fix = 99;
    push(2'd3); push(2'd1); wait_start();
    @(negedge clk); #1 reset = 1'b1;
    #1;
    check("t6_start_drop", motor_start, 0);
    check("t6_sel_zero", motor_sel, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", req_ready, 1);
    check("t6_fault_clr", fault, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    v0 = m_vend; r0 = m_ref;
    repeat (30) @(negedge clk);
    check("t6_no_vend", m_vend - v0, 0);
    check("t6_no_refund", m_ref - r0, 0);
    check("t6_idle", busy, 0);

    // Random traffic against the model
    d_fix = -1;
    repeat (600) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_code  = 2'($urandom_range(0, 3));
      refill    = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk); req_valid = 1'b0; req_code = 2'd0; refill = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
